// File: rtl/flit_injector.sv
// Packet-atomic two-source flit injector: round-robin packet arbitration
// between CPU and forwarded streams, merged through a 2-entry output FIFO.
package types;
    typedef logic [31:0] flit_t;
endpackage

module flit_injector #(
    parameter int MAX_PACKET_FLITS = 16
) (
    input  logic         nocclk,
    input  logic         rst_n,
    input  types::flit_t cpu_to_noc_pushed_flit,
    input  logic         cpu_to_noc_pushed_flit_valid,
    input  logic         cpu_to_noc_pushed_flit_tail,
    output logic         cpu_to_noc_pushed_flit_ready,
    input  types::flit_t forwarded_flit,
    input  logic         forwarded_flit_valid,
    input  logic         forwarded_flit_tail,
    output logic         forwarded_flit_ready,
    output types::flit_t transmit_flit,
    output logic         transmit_flit_valid,
    input  logic         transmit_flit_ready,
    output logic         packet_overrun
);
    localparam int CNT_W = $clog2(MAX_PACKET_FLITS + 1);

    typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_FWD} state_t;

    state_t       state, state_nxt;
    logic         last_cpu, last_cpu_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic         ovr_nxt;
    logic         init_done;
    logic         sel_cpu, sel_fwd;
    logic         can_push, push, pop;
    types::flit_t push_flit;
    logic         push_tail;

    types::flit_t mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   occ;

    // Readys come from registered occupancy only, so a full FIFO never
    // accepts a push even when it is popping in the same cycle.
    assign can_push = init_done && (occ != 2'd2);
    assign pop      = (occ != 2'd0) && transmit_flit_ready;

    assign transmit_flit_valid = (occ != 2'd0);
    assign transmit_flit       = transmit_flit_valid ? mem[rd_ptr] : '0;

    always_comb begin
        sel_cpu      = 1'b0;
        sel_fwd      = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        cnt_inc      = cnt + 1'b1;
        last_cpu_nxt = last_cpu;
        ovr_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_to_noc_pushed_flit_valid && forwarded_flit_valid) begin
                    sel_fwd = last_cpu;
                    sel_cpu = !last_cpu;
                end else begin
                    sel_cpu = cpu_to_noc_pushed_flit_valid;
                    sel_fwd = forwarded_flit_valid;
                end
            end
            GRANT_CPU: sel_cpu = 1'b1;
            GRANT_FWD: sel_fwd = 1'b1;
            default:   ;
        endcase

        cpu_to_noc_pushed_flit_ready = sel_cpu && can_push;
        forwarded_flit_ready         = sel_fwd && can_push;
        push = (cpu_to_noc_pushed_flit_valid && cpu_to_noc_pushed_flit_ready) ||
               (forwarded_flit_valid && forwarded_flit_ready);
        push_flit = sel_cpu ? cpu_to_noc_pushed_flit : forwarded_flit;
        push_tail = sel_cpu ? cpu_to_noc_pushed_flit_tail : forwarded_flit_tail;

        if (push) begin
            // Remembering the source on every flit is enough: it only matters
            // once the packet is released back to IDLE.
            last_cpu_nxt = sel_cpu;
            if (push_tail) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (cnt_inc == CNT_W'(MAX_PACKET_FLITS)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ovr_nxt   = 1'b1;
            end else begin
                state_nxt = sel_cpu ? GRANT_CPU : GRANT_FWD;
                cnt_nxt   = cnt_inc;
            end
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_cpu       <= 1'b1;
            cnt            <= '0;
            packet_overrun <= 1'b0;
            init_done      <= 1'b0;
        end else begin
            state          <= state_nxt;
            last_cpu       <= last_cpu_nxt;
            cnt            <= cnt_nxt;
            packet_overrun <= ovr_nxt;
            init_done      <= 1'b1;
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_flit;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: packet-level queue model checked every
// cycle, plus literal output-order/timing expectations per scenario.
module tb_flit_injector;
    localparam int MAXF = 4;

    typedef struct {
        types::flit_t d;
        bit           tail;
    } src_flit_t;

    typedef struct {
        types::flit_t d;
        int           cyc;
    } log_t;

    logic         nocclk = 1'b0;
    logic         rst_n  = 1'b0;
    types::flit_t cpu_flit = '0, fwd_flit = '0, transmit_flit;
    logic         cpu_valid = 1'b0, cpu_tail = 1'b0, cpu_ready;
    logic         fwd_valid = 1'b0, fwd_tail = 1'b0, fwd_ready;
    logic         tx_valid, tx_rdy = 1'b1, packet_overrun;

    flit_injector #(.MAX_PACKET_FLITS(MAXF)) dut (
        .nocclk                       (nocclk),
        .rst_n                        (rst_n),
        .cpu_to_noc_pushed_flit       (cpu_flit),
        .cpu_to_noc_pushed_flit_valid (cpu_valid),
        .cpu_to_noc_pushed_flit_tail  (cpu_tail),
        .cpu_to_noc_pushed_flit_ready (cpu_ready),
        .forwarded_flit               (fwd_flit),
        .forwarded_flit_valid         (fwd_valid),
        .forwarded_flit_tail          (fwd_tail),
        .forwarded_flit_ready         (fwd_ready),
        .transmit_flit                (transmit_flit),
        .transmit_flit_valid          (tx_valid),
        .transmit_flit_ready          (tx_rdy),
        .packet_overrun               (packet_overrun)
    );

    always #5 nocclk = ~nocclk;

    int total = 0, bad = 0;
    int cyc = 0, ovr_seen = 0;

    src_flit_t    cpu_q[$], fwd_q[$];
    types::flit_t out_q[$];   // model of flits sitting in the output buffer
    log_t         log_q[$];
    types::flit_t want[$];

    // Packet-level model state: 0 none, 1 cpu owns link, 2 fwd owns link
    int owner, m_cnt;
    bit m_last_cpu, m_ovr, m_first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = 0; m_cnt = 0; m_last_cpu = 1'b1; m_ovr = 1'b0; m_first = 1'b1;
        out_q.delete();
    endtask

    task automatic add_pkt(input bit is_cpu, input int n, input types::flit_t base, input bit with_tail);
        src_flit_t f;
        for (int i = 0; i < n; i++) begin
            f.d = base + types::flit_t'(i);
            f.tail = with_tail && (i == n - 1);
            if (is_cpu) cpu_q.push_back(f); else fwd_q.push_back(f);
        end
    endtask

    // One cycle: drive at negedge, compare against model, advance model.
    task automatic step();
        int pick;
        bit can_push, e_rc, e_rf, pushed, tail;
        types::flit_t pf;
        log_t l;
        cpu_valid = cpu_q.size() > 0;
        cpu_flit  = cpu_valid ? cpu_q[0].d : '0;
        cpu_tail  = cpu_valid ? cpu_q[0].tail : 1'b0;
        fwd_valid = fwd_q.size() > 0;
        fwd_flit  = fwd_valid ? fwd_q[0].d : '0;
        fwd_tail  = fwd_valid ? fwd_q[0].tail : 1'b0;
        #1;
        if (owner != 0) pick = owner;
        else if (cpu_valid && fwd_valid) pick = m_last_cpu ? 2 : 1;
        else if (cpu_valid) pick = 1;
        else if (fwd_valid) pick = 2;
        else pick = 0;
        can_push = (out_q.size() < 2) && !m_first;
        e_rc = (pick == 1) && can_push;
        e_rf = (pick == 2) && can_push;

        chk("tx_valid", tx_valid, out_q.size() > 0);
        chk("tx_flit", transmit_flit, out_q.size() > 0 ? out_q[0] : '0);
        chk("cpu_ready", cpu_ready, e_rc);
        chk("fwd_ready", fwd_ready, e_rf);
        chk("overrun", packet_overrun, m_ovr);

        if (tx_valid && tx_rdy) begin
            l.d = transmit_flit; l.cyc = cyc;
            log_q.push_back(l);
        end
        if (packet_overrun) ovr_seen++;

        pushed = (e_rc && cpu_valid) || (e_rf && fwd_valid);
        pf = '0; tail = 1'b0;
        if (pushed) begin
            if (pick == 1) begin pf = cpu_q[0].d; tail = cpu_q[0].tail; void'(cpu_q.pop_front()); end
            else begin pf = fwd_q[0].d; tail = fwd_q[0].tail; void'(fwd_q.pop_front()); end
        end
        if (out_q.size() > 0 && tx_rdy) void'(out_q.pop_front());
        m_ovr = 1'b0;
        if (pushed) begin
            out_q.push_back(pf);
            m_cnt++;
            m_last_cpu = (pick == 1);
            if (tail) begin owner = 0; m_cnt = 0; end
            else if (m_cnt == MAXF) begin owner = 0; m_cnt = 0; m_ovr = 1'b1; end
            else owner = pick;
        end
        m_first = 1'b0;
        @(posedge nocclk);
        @(negedge nocclk);
        cyc++;
    endtask

    task automatic run_until_idle(input int maxc);
        int n = 0;
        while ((cpu_q.size() > 0 || fwd_q.size() > 0 || out_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        chk("run_bound", n < maxc, 1);
    endtask

    task automatic check_log(input string name, input bit contiguous);
        chk({name, "_len"}, log_q.size(), want.size());
        for (int i = 0; i < want.size() && i < log_q.size(); i++) begin
            chk({name, "_data"}, log_q[i].d, want[i]);
            if (contiguous) chk({name, "_gap"}, log_q[i].cyc, log_q[0].cyc + i);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_flit", transmit_flit, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_fwd_ready", fwd_ready, 0);
        chk("rst_overrun", packet_overrun, 0);
        cpu_q.delete(); fwd_q.delete();
        cpu_valid = 1'b0; fwd_valid = 1'b0;
        repeat (2) begin @(posedge nocclk); @(negedge nocclk); end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int c0;
        model_reset();
        @(negedge nocclk);
        do_reset();
        step();

        // Single source: 3-flit CPU packet appears on the next three cycles
        log_q.delete(); tx_rdy = 1'b1;
        add_pkt(1, 3, 32'h3100_0001, 1);
        c0 = cyc;
        run_until_idle(20);
        want = '{32'h3100_0001, 32'h3100_0002, 32'h3100_0003};
        check_log("single", 1);
        if (log_q.size() > 0) chk("single_latency", log_q[0].cyc, c0 + 1);

        // Contention right after reset: forwarded packet first
        do_reset();
        step();
        log_q.delete();
        add_pkt(1, 2, 32'hC320_0001, 1);
        add_pkt(0, 2, 32'hF320_0001, 1);
        run_until_idle(20);
        want = '{32'hF320_0001, 32'hF320_0002, 32'hC320_0001, 32'hC320_0002};
        check_log("contend", 1);

        // Alternating single-flit packets from both sources
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            add_pkt(1, 1, 32'hC360_0000 + types::flit_t'(i), 1);
            add_pkt(0, 1, 32'hF360_0000 + types::flit_t'(i), 1);
        end
        run_until_idle(30);
        want = '{32'hF360_0000, 32'hC360_0000, 32'hF360_0001, 32'hC360_0001,
                 32'hF360_0002, 32'hC360_0002, 32'hF360_0003, 32'hC360_0003};
        check_log("alternate", 1);

        // Backpressure: 5 stalled cycles during a 4-flit packet
        log_q.delete();
        add_pkt(1, 4, 32'h3300_0001, 1);
        tx_rdy = 1'b0;
        repeat (5) step();
        chk("bp_hold_flit", transmit_flit, 32'h3300_0001);
        chk("bp_hold_valid", tx_valid, 1);
        chk("bp_src_ready", cpu_ready, 0);
        tx_rdy = 1'b1;
        run_until_idle(20);
        want = '{32'h3300_0001, 32'h3300_0002, 32'h3300_0003, 32'h3300_0004};
        check_log("backpressure", 1);

        // Overrun: 6 tail-less CPU flits with MAX=4, forwarded traffic waiting
        log_q.delete(); ovr_seen = 0;
        add_pkt(1, 6, 32'hC340_0001, 0);
        add_pkt(0, 1, 32'hF340_0001, 1);
        add_pkt(0, 1, 32'hF340_0002, 1);
        run_until_idle(30);
        want = '{32'hF340_0001, 32'hC340_0001, 32'hC340_0002, 32'hC340_0003,
                 32'hC340_0004, 32'hF340_0002, 32'hC340_0005, 32'hC340_0006};
        check_log("overrun", 1);
        chk("overrun_pulses", ovr_seen, 1);

        // Reset in the middle of a 5-flit packet
        do_reset();
        log_q.delete();
        add_pkt(1, 5, 32'h3500_0001, 1);
        repeat (3) step();
        chk("mid_tx_valid_before", tx_valid, 1);
        do_reset();
        log_q.delete();
        add_pkt(1, 3, 32'h3510_0001, 1);
        run_until_idle(20);
        want = '{32'h3510_0001, 32'h3510_0002, 32'h3510_0003};
        check_log("after_reset", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
